// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall controller for an in-order pipeline with NSTAGES latches.
//   Each cycle it decides whether the PC and each pipeline latch advance,
//   hold, or are flushed. It handles these cases in priority order: halted,
//   data-memory freeze, taken-branch flush, load-use bubbling, fetch miss,
//   and normal advance. It also counts stalled cycles, saturating at the
//   counter maximum.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   ihit, dhit          fetch complete / data access complete
//   dREN, dWEN          memory-stage read / write request
//   ex_memread, ex_rd   load in EX and its destination register
//   id_rs, id_rt        ID-stage source registers
//   id_rs_used/_rt_used source-valid flags
//   branch_taken        taken redirect from latch BR_STAGE
//   halt                halt reaching the last stage
//   pcW                 PC write enable
//   stageW, stageRST    per-latch write enables / flushes (bubble insert)
//   halted              controller parked in HALTED
//   stall_cycles        saturating count of stalled cycles
//
// state  | meaning
// RUN    | normal operation; load-use and fetch-miss checks are live
// LU     | emitting the remaining load-use bubbles (lu_cnt_q counts them)
// HALTED | pipeline frozen until reset
module pipeline_hazard_ctrl #(
  parameter int NSTAGES   = 4,
  parameter int REGW      = 5,
  parameter int BR_STAGE  = 2,
  parameter int LU_CYCLES = 1,
  parameter int CNTW      = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dREN,
  input  logic               dWEN,
  input  logic               ex_memread,
  input  logic [REGW-1:0]    ex_rd,
  input  logic [REGW-1:0]    id_rs,
  input  logic [REGW-1:0]    id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               branch_taken,
  input  logic               halt,
  output logic               pcW,
  output logic [NSTAGES-1:0] stageW,
  output logic [NSTAGES-1:0] stageRST,
  output logic               halted,
  output logic [CNTW-1:0]    stall_cycles
);

  typedef enum logic [1:0] {RUN, LU, HALTED} state_t;

  state_t          state_q, state_d;
  logic [2:0]      lu_cnt_q, lu_cnt_d;
  logic [CNTW-1:0] stall_q, stall_d;

  logic               dfreeze;
  logic               lu_hit;
  logic [NSTAGES-1:0] br_mask;

  assign dfreeze = (dREN | dWEN) & ~dhit;
  assign lu_hit  = ex_memread && (ex_rd != '0) &&
                   ((id_rs_used && (id_rs == ex_rd)) ||
                    (id_rt_used && (id_rt == ex_rd)));

  // Latches younger than the branch (index below BR_STAGE) hold wrong-path work.
  always_comb begin
    for (int j = 0; j < NSTAGES; j++) begin
      br_mask[j] = (j < BR_STAGE);
    end
  end

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    stall_d  = stall_q;
    pcW      = 1'b1;
    stageW   = '1;
    stageRST = '0;

    if (RST) begin
      pcW      = 1'b0;
      stageW   = '0;
      stageRST = '1;
      state_d  = RUN;
      lu_cnt_d = 3'd0;
      stall_d  = '0;
    end else if (state_q == HALTED) begin
      pcW    = 1'b0;
      stageW = '0;
    end else if (dfreeze) begin
      // Whole pipeline freezes and state and lu_cnt hold until the access completes.
      pcW    = 1'b0;
      stageW = '0;
    end else begin
      if (branch_taken) begin
        // Squashing the dependent also cancels any bubbles still owed to it.
        stageRST = br_mask;
        stageW   = ~br_mask;
        state_d  = RUN;
        lu_cnt_d = 3'd0;
      end else if ((state_q == LU) || lu_hit) begin
        pcW         = 1'b0;
        stageW[0]   = 1'b0;
        stageW[1]   = 1'b0;
        stageRST[1] = 1'b1;
        if (state_q == LU) begin
          if (lu_cnt_q <= 3'd1) begin
            state_d  = RUN;
            lu_cnt_d = 3'd0;
          end else begin
            lu_cnt_d = lu_cnt_q - 3'd1;
          end
        end else if (LU_CYCLES > 1) begin
          state_d  = LU;
          lu_cnt_d = 3'(LU_CYCLES - 1);
        end
      end else if (!ihit) begin
        pcW         = 1'b0;
        stageW[0]   = 1'b0;
        stageRST[0] = 1'b1;
      end
      if (halt) begin
        state_d = HALTED;
      end
    end

    if (!RST && (state_q != HALTED) && !pcW && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      lu_cnt_q <= 3'd0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign halted       = (state_q == HALTED);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed and random stimulus for pipeline_hazard_ctrl. The DUT uses
//   NSTAGES=4, BR_STAGE=2, LU_CYCLES=2 and CNTW=4. The expected outputs come
//   from a cycle model that tracks three things: the bubbles still owed, a
//   halted flag, and a saturating stall count.
module tb_pipeline_hazard_ctrl;

  localparam int NSTAGES   = 4;
  localparam int REGW      = 5;
  localparam int BR_STAGE  = 2;
  localparam int LU_CYCLES = 2;
  localparam int CNTW      = 4;
  localparam int SAT       = 15;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, dREN, dWEN, ex_memread;
  logic [REGW-1:0] ex_rd, id_rs, id_rt;
  logic id_rs_used, id_rt_used, branch_taken, halt;
  logic pcW, halted;
  logic [NSTAGES-1:0] stageW, stageRST;
  logic [CNTW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  int m_bub   = 0;
  bit m_halt  = 0;
  int m_stall = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(
    .NSTAGES(NSTAGES), .REGW(REGW), .BR_STAGE(BR_STAGE),
    .LU_CYCLES(LU_CYCLES), .CNTW(CNTW)
  ) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .branch_taken(branch_taken), .halt(halt),
    .pcW(pcW), .stageW(stageW), .stageRST(stageRST), .halted(halted),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RST = 0; ihit = 1; dhit = 1; dREN = 0; dWEN = 0; ex_memread = 0;
    ex_rd = '0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    branch_taken = 0; halt = 0;
  endtask

  // One clock: check outputs for the inputs already driven, then advance the model.
  task automatic step();
    bit fz, lh;
    logic e_pcw;
    logic [3:0] e_w, e_r;
    fz = (dREN || dWEN) && !dhit;
    lh = ex_memread && (ex_rd != 0) &&
         ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
    if (RST) begin
      e_pcw = 0; e_w = 4'b0000; e_r = 4'b1111;
    end else if (m_halt || fz) begin
      e_pcw = 0; e_w = 4'b0000; e_r = 4'b0000;
    end else if (branch_taken) begin
      e_pcw = 1; e_w = 4'b1100; e_r = 4'b0011;
    end else if (m_bub > 0 || lh) begin
      e_pcw = 0; e_w = 4'b1100; e_r = 4'b0010;
    end else if (!ihit) begin
      e_pcw = 0; e_w = 4'b1110; e_r = 4'b0001;
    end else begin
      e_pcw = 1; e_w = 4'b1111; e_r = 4'b0000;
    end
    #1;
    chk("pcW", pcW, e_pcw);
    chk("stageW", stageW, e_w);
    chk("stageRST", stageRST, e_r);
    if (!RST) chk("halted", halted, m_halt);
    chk("stall_cycles", stall_cycles, m_stall);

    if (RST) begin
      m_bub = 0; m_halt = 0; m_stall = 0;
    end else if (!m_halt) begin
      if (!e_pcw) m_stall = (m_stall >= SAT) ? SAT : m_stall + 1;
      if (!fz) begin
        if (branch_taken) m_bub = 0;
        else if (m_bub > 0) m_bub--;
        else if (lh) m_bub = LU_CYCLES - 1;
        if (halt) m_halt = 1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(input int n);
    idle(); RST = 1;
    for (int i = 0; i < n; i++) step();
    RST = 0;
  endtask

  initial begin
    idle();
    do_reset(2);
    chk("reset_stall", stall_cycles, 0);
    chk("reset_halted", halted, 0);

    // Load-use with two bubbles
    ex_memread = 1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1;
    step();
    ex_memread = 0;
    step();
    idle();
    step();
    chk("lu_stall_total", stall_cycles, 2);
    chk("lu_resume_pcW", pcW, 1);

    // Data freeze for three cycles, then the hit cycle advances
    do_reset(1);
    dREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) step();
    dhit = 1;
    #1 chk("dhit_stageW", stageW, 4'b1111);
    step();
    idle();
    step();
    chk("freeze_stall_total", stall_cycles, 3);

    // Branch wins over a simultaneous load-use hit
    do_reset(1);
    ex_memread = 1; ex_rd = 5'd3; id_rt = 5'd3; id_rt_used = 1; branch_taken = 1;
    step();
    idle();
    step();
    chk("branch_no_bubble", stall_cycles, 0);

    // r0 never creates a load-use hazard; fetch miss alone
    ex_memread = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rs_used = 1;
    step();
    idle(); ihit = 0;
    step();
    idle();

    // Halt blocked by freeze, taken once the access completes
    do_reset(1);
    halt = 1; dREN = 1; dhit = 0;
    step(); step();
    dhit = 1;
    step();
    idle();
    for (int i = 0; i < 8; i++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); dREN = 1'($urandom);
      branch_taken = 1'($urandom); halt = 1'($urandom); ex_memread = 1'($urandom);
      step();
    end
    chk("halted_sticky", halted, 1);
    idle();

    // Saturation of the stall counter
    do_reset(1);
    ihit = 0;
    for (int i = 0; i < 20; i++) step();
    chk("stall_saturated", stall_cycles, SAT);
    idle();

    // Reset in the middle of a load-use sequence
    ex_memread = 1; ex_rd = 5'd9; id_rs = 5'd9; id_rs_used = 1;
    step();
    RST = 1;
    #1 chk("rst_stageRST", stageRST, 4'b1111);
    step();
    idle();
    chk("rst_stall_clear", stall_cycles, 0);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      RST          = ($urandom_range(0, 59) == 0);
      ihit         = ($urandom_range(0, 7) != 0);
      dREN         = ($urandom_range(0, 5) == 0);
      dWEN         = ($urandom_range(0, 9) == 0);
      dhit         = 1'($urandom);
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_rs_used   = 1'($urandom);
      id_rt_used   = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      halt         = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, 4, number of pipeline latches (0 = IF/ID … NSTAGES-1 = last); legal range 3..8.
REQ-002 SHALL have parameter REGW, 5, register-index width.
REQ-003 SHALL have parameter BR_STAGE, 2, latch index whose instruction resolves branches; legal range 1..NSTAGES-1.
REQ-004 SHALL have parameter LU_CYCLES, 1, load-use bubble count; legal range 1..7.
REQ-005 SHALL have parameter CNTW, 16, stall-counter width.
REQ-006 SHALL have ports: CLK in 1 clock; RST in 1 reset. One clock; reset is synchronous and active-high.
REQ-007 SHALL have ports: ihit in 1 fetch complete; dhit in 1 data access complete; dREN in 1, dWEN in 1 memory-stage read/write request.
REQ-008 SHALL have ports: ex_memread in 1 load in EX; ex_rd in REGW its destination; id_rs, id_rt in REGW ID sources; id_rs_used, id_rt_used in 1 source-valid flags.
REQ-009 SHALL have ports: branch_taken in 1 taken redirect from latch BR_STAGE; halt in 1 halt at last stage.
REQ-010 SHALL have ports: pcW out 1 PC write enable; stageW out NSTAGES latch enables; stageRST out NSTAGES latch flushes (bubble insert); halted out 1; stall_cycles out CNTW.

Function
REQ-011 SHALL implement FSM states RUN, LU (load-use bubbling), HALTED; state, lu_cnt (3 bits), stall_cycles registered; all other outputs combinational from state and inputs.
REQ-012 SHALL evaluate each cycle in strict priority: HALTED > dfreeze > branch flush > load-use > fetch miss > normal.
REQ-013 SHALL define dfreeze = (dREN|dWEN) & !dhit; while dfreeze: pcW=0, stageW=all 0, stageRST=all 0; state and lu_cnt hold.
REQ-014 SHALL, in the cycle dhit=1 with a pending access, apply lower-priority rules normally (pipeline advances that cycle, zero extra latency).
REQ-015 SHALL, on branch_taken without dfreeze: pcW=1, stageRST[j]=1 and stageW[j]=0 for j<BR_STAGE, stageW[j]=1 for j>=BR_STAGE; state→RUN, lu_cnt→0 (squashed load-use dependent cancelled).
REQ-016 SHALL define lu_hit = ex_memread & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
REQ-017 SHALL, in RUN with lu_hit (no higher event): pcW=0, stageW[0]=0, stageRST[1]=1, stageW[1]=0, others stageW=1; if LU_CYCLES>1 go to LU with lu_cnt=LU_CYCLES-1, else stay RUN.
REQ-018 SHALL, in LU (no higher event): same outputs as REQ-017; lu_cnt decrements per cycle; at lu_cnt==1 return to RUN after that cycle; lu_hit is not re-evaluated in LU.
REQ-019 SHALL, on !ihit (no higher event, state RUN, no lu_hit): pcW=0, stageRST[0]=1, stageW[0]=0, stageW[j]=1 for j>=1.
REQ-020 SHALL otherwise output pcW=1, stageW=all 1, stageRST=all 0.
REQ-021 SHALL, on halt without dfreeze, enter HALTED next cycle; in HALTED: pcW=0, stageW=all 0, stageRST=all 0, halted=1, exit only by RST.
REQ-022 SHALL increment stall_cycles each cycle pcW=0 and state≠HALTED, saturating at 2^CNTW-1 (no wrap).
REQ-023 SHALL ignore dREN/dWEN simultaneous assertion semantics beyond REQ-013 (either counts as pending).

Reset
REQ-024 SHALL, while RST=1 at a rising CLK edge, set state=RUN, lu_cnt=0, stall_cycles=0, halted=0.
REQ-025 SHALL, while RST=1, drive pcW=0, stageW=all 0, stageRST=all 1, overriding every input including halt and branch_taken.
REQ-026 SHALL, when RST asserts mid-LU or mid-dfreeze, abandon the operation; first cycle after RST deasserts behaves as fresh RUN.

Verification
REQ-027 SHALL cover: LU_CYCLES=2, ex_memread=1, ex_rd=8, id_rs=8, id_rs_used=1, ihit=1 -> 2 cycles of pcW=0, stageRST=4'b0010, stageW=4'b1100, then pcW=1, stall_cycles=2.
REQ-028 SHALL cover: dREN=1, dhit=0 for 3 cycles then dhit=1 -> stageW=0 for 3 cycles, stageW=4'b1111 on dhit cycle, stall_cycles=3.
REQ-029 SHALL cover: BR_STAGE=2, branch_taken=1 same cycle as lu_hit -> pcW=1, stageRST=4'b0011, stageW=4'b1100, state RUN next cycle.
REQ-030 SHALL cover: ex_rd=0 with matching id_rs=0 -> no stall; ihit=0 alone -> pcW=0, stageRST=4'b0001.
REQ-031 SHALL cover: halt=1 with dREN=1, dhit=0 -> frozen, HALTED only after dhit; then all inputs toggled -> outputs constant, halted=1 until RST.
REQ-032 SHALL cover: CNTW=4, 20 stall cycles -> stall_cycles saturates at 15; RST mid-LU -> stall_cycles=0, stageRST=all 1 during reset.
